// File: rtl/parking_timer_pkg.sv
// Shared constants and prescaler operation encoding for the parking timer.
// One operation is chosen per clock edge; a lower-priority request never overrides a higher one.
package parking_timer_pkg;

  localparam int DEFAULT_DIV_100K = 100000;
  localparam int DIV_W_DEFAULT    = 24;
  localparam int CNT_W_DEFAULT    = 16;

  // Ordered so that a larger code always means a higher-priority action.
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,  // frozen, tick forced low
    OP_COUNT = 3'd1,  // normal prescale step
    OP_SKIP  = 3'd2,  // zero-divisor load: counter advances, outputs quiet
    OP_LOAD  = 3'd3,  // accept new divisor, restart count
    OP_CLR   = 3'd4   // clear counters and outputs, keep divisor
  } presc_op_e;

  function automatic presc_op_e presc_op_decode(
    input logic clr,
    input logic div_load,
    input logic div_nonzero,
    input logic en
  );
    presc_op_e op;
    op = OP_HOLD;
    if (clr)
      op = OP_CLR;
    else if (div_load && div_nonzero)
      op = OP_LOAD;
    else if (div_load && en)
      op = OP_SKIP;
    else if (!div_load && en)
      op = OP_COUNT;
    return op;
  endfunction

endpackage

// File: rtl/parking_timer_divider_tick_prescaler.sv
// Programmable prescaler: registered TICK and CLK_OUT every div_reg enabled cycles.
// TICK is high the cycle after terminal count; o_term flags that edge combinationally. No backpressure.
module tick_prescaler
  import parking_timer_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_100K
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_value,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic             o_term
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk_out;

  presc_op_e        w_op;
  logic             w_last;

  assign w_op   = presc_op_decode(i_clr, i_div_load, (i_div_value != '0), i_en);
  // r_div is never zero, so the subtraction cannot wrap.
  assign w_last = (r_cnt == (r_div - ONE));
  assign o_term = (w_op == OP_COUNT) && w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      case (w_op)
        OP_CLR: begin
          r_cnt     <= '0;
          r_tick    <= 1'b0;
          r_clk_out <= 1'b0;
        end
        OP_LOAD: begin
          r_div  <= i_div_value;
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end
        OP_SKIP: begin
          r_cnt  <= w_last ? '0 : r_cnt + ONE;
          r_tick <= 1'b0;
        end
        OP_COUNT: begin
          if (w_last) begin
            r_cnt     <= '0;
            r_tick    <= 1'b1;
            r_clk_out <= ~r_clk_out;
          end else begin
            r_cnt  <= r_cnt + ONE;
            r_tick <= 1'b0;
          end
        end
        default: r_tick <= 1'b0;
      endcase
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;

endmodule

// File: rtl/parking_timer_divider.sv
// Clock divider plus saturating elapsed-tick counter and combinational alarm compare.
// ELAPSED updates on the same edge TICK is registered; ALARM is same-cycle. No backpressure.
module parking_timer_divider
  import parking_timer_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_100K,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             i_clk_in,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_value,
  input  logic [CNT_W-1:0] i_alarm_value,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic [CNT_W-1:0] o_elapsed,
  output logic             o_alarm
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_elapsed;
  logic             w_term;
  logic             w_sat;

  tick_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .i_clk       (i_clk_in),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_clr       (i_clr),
    .i_div_load  (i_div_load),
    .i_div_value (i_div_value),
    .o_tick      (o_tick),
    .o_clk_out   (o_clk_out),
    .o_term      (w_term)
  );

  assign w_sat = &r_elapsed;

  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n)
      r_elapsed <= '0;
    else if (i_clr)
      r_elapsed <= '0;
    else if (w_term && !w_sat)
      r_elapsed <= r_elapsed + ONE;
  end

  assign o_elapsed = r_elapsed;
  assign o_alarm   = (i_alarm_value != '0) && (r_elapsed >= i_alarm_value);

endmodule

// File: tb/tb_parking_timer_divider.sv
// Directed bench for parking_timer_divider: a 16-bit instance (default divisor 6) and a 4-bit one (divisor 1).
module tb_parking_timer_divider;

  logic        clk;
  logic        rst_n;
  logic        en, clr, div_load;
  logic [23:0] div_value;
  logic [15:0] alarm_value;
  logic        tick, clk_out, alarm;
  logic [15:0] elapsed;

  logic        en4;
  logic [3:0]  alarm4;
  logic        tick4, clk_out4, alarm_o4;
  logic [3:0]  elapsed4;

  int n_checks = 0;
  int n_errors = 0;

  parking_timer_divider #(.DIV_W(24), .DEFAULT_DIV(6), .CNT_W(16)) dut (
    .i_clk_in      (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_clr         (clr),
    .i_div_load    (div_load),
    .i_div_value   (div_value),
    .i_alarm_value (alarm_value),
    .o_tick        (tick),
    .o_clk_out     (clk_out),
    .o_elapsed     (elapsed),
    .o_alarm       (alarm)
  );

  parking_timer_divider #(.DIV_W(24), .DEFAULT_DIV(1), .CNT_W(4)) dut4 (
    .i_clk_in      (clk),
    .i_rst_n       (rst_n),
    .i_en          (en4),
    .i_clr         (1'b0),
    .i_div_load    (1'b0),
    .i_div_value   (24'd0),
    .i_alarm_value (alarm4),
    .o_tick        (tick4),
    .o_clk_out     (clk_out4),
    .o_elapsed     (elapsed4),
    .o_alarm       (alarm_o4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_value = '0;
    alarm_value = 16'd0; en4 = 1'b0; alarm4 = 4'd0;
    #22;
    chk("rst_tick", tick, 1'b0);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_elapsed", elapsed, 16'd0);
    chk("rst_alarm", alarm, 1'b0);
    alarm_value = 16'd1;
    #1;
    chk("rst_alarm_nz_limit", alarm, 1'b0);
    alarm_value = 16'd0;

    // Load divisor 4 on the first edge after release, then 20 counting edges.
    rst_n = 1'b1;
    en = 1'b1; div_load = 1'b1; div_value = 24'd4;
    step();
    chk("load4_tick", tick, 1'b0);
    div_load = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("div4_tick_e%0d", i), tick, (i % 4 == 0));
      chk($sformatf("div4_clk_e%0d", i), clk_out, ((i / 4) % 2));
      chk($sformatf("div4_elap_e%0d", i), elapsed, i / 4);
    end

    // Zero-divisor load at cnt=2 is ignored; tick still two edges later.
    step(); step();
    div_load = 1'b1; div_value = 24'd0;
    step();
    chk("load0_tick", tick, 1'b0);
    chk("load0_elapsed", elapsed, 16'd5);
    div_load = 1'b0;
    step();
    chk("after_load0_tick", tick, 1'b1);
    chk("after_load0_elapsed", elapsed, 16'd6);
    chk("after_load0_clk", clk_out, 1'b0);

    // Divisor 1: tick every cycle, CLK_OUT toggles every cycle.
    div_load = 1'b1; div_value = 24'd1;
    step();
    chk("load1_tick", tick, 1'b0);
    chk("load1_clk", clk_out, 1'b0);
    div_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("div1_tick_e%0d", i), tick, 1'b1);
      chk($sformatf("div1_clk_e%0d", i), clk_out, i % 2);
      chk($sformatf("div1_elap_e%0d", i), elapsed, 6 + i);
    end

    // EN low at cnt=2 freezes everything; resume gives tick two edges later.
    div_load = 1'b1; div_value = 24'd4;
    step();
    div_load = 1'b0;
    step(); step();
    en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("frz_tick_e%0d", i), tick, 1'b0);
      chk($sformatf("frz_clk_e%0d", i), clk_out, 1'b0);
      chk($sformatf("frz_elap_e%0d", i), elapsed, 16'd10);
    end
    en = 1'b1;
    step();
    chk("resume_tick_e1", tick, 1'b0);
    step();
    chk("resume_tick_e2", tick, 1'b1);
    chk("resume_elapsed", elapsed, 16'd11);
    chk("resume_clk", clk_out, 1'b1);

    // CLR wins over a simultaneous load of 8; divisor stays 4.
    clr = 1'b1; div_load = 1'b1; div_value = 24'd8;
    step();
    chk("clr_elapsed", elapsed, 16'd0);
    chk("clr_clk", clk_out, 1'b0);
    chk("clr_tick", tick, 1'b0);
    clr = 1'b0; div_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("postclr_tick_e%0d", i), tick, (i == 4));
    end
    chk("postclr_elapsed", elapsed, 16'd1);
    alarm_value = 16'd1;
    #1;
    chk("alarm_eq", alarm, 1'b1);
    alarm_value = 16'd2;
    #1;
    chk("alarm_raised_limit", alarm, 1'b0);
    alarm_value = 16'd0;

    // Async reset mid-count with div=5, cnt=3, CLK_OUT=1.
    div_load = 1'b1; div_value = 24'd5;
    step();
    div_load = 1'b0;
    repeat (13) step();
    chk("prerst_clk", clk_out, 1'b1);
    chk("prerst_elapsed", elapsed, 16'd3);
    alarm_value = 16'd3;
    #1;
    chk("prerst_alarm", alarm, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", tick, 1'b0);
    chk("arst_clk", clk_out, 1'b0);
    chk("arst_elapsed", elapsed, 16'd0);
    chk("arst_alarm", alarm, 1'b0);
    #3;
    rst_n = 1'b1;
    alarm_value = 16'd0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("default_div_tick_e%0d", i), tick, (i == 6));
    end

    // 4-bit instance, divisor 1: alarm at 10, saturation at 15.
    en = 1'b0;
    en4 = 1'b1; alarm4 = 4'd10;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("c4_tick_e%0d", i), tick4, 1'b1);
      chk($sformatf("c4_clk_e%0d", i), clk_out4, i % 2);
      chk($sformatf("c4_elap_e%0d", i), elapsed4, (i > 15) ? 15 : i);
      chk($sformatf("c4_alarm_e%0d", i), alarm_o4, (i >= 10));
    end
    alarm4 = 4'd0;
    #1;
    chk("c4_alarm_disabled", alarm_o4, 1'b0);
    alarm4 = 4'd15;
    #1;
    chk("c4_alarm_at_max", alarm_o4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
